uart_8250_bus_ctrl: RTL and testbench
=====================================

// Module: uart_8250_bus_ctrl
// PURPOSE
//  Wishbone master that configures and shares the uart_8250 register port (byte regs at BASE+0..7).
//  After reset it runs a fixed init sequence: baud divisor via DLAB, line format, FCR, IER.
//  It then arbitrates that single port round-robin between two requesters (CPU-side, DMA-side).
//  Sits between the SoC interconnect and uart_8250; the only block driving the UART's Wishbone slave.
// PARAMETERS
//  BASE     32'h1250_0000  UART base address; offset placed in ADR[2:0]
//  DIVISOR  16'd1          baud divisor: DLL=DIVISOR[7:0], DLM=DIVISOR[15:8]
//  LCR_FMT  8'h03          final LCR value (8N1, DLAB=0)
//  FCR_VAL  8'h07          FIFO control value
//  IER_VAL  8'h01          interrupt enable value
//  TIMEOUT  16             cycles to wait for m_ACK_I before aborting a cycle
// PORTS
//  CLK_I        in   1   clock, all logic on rising edge
//  RST_I        in   1   synchronous reset, active-high
//  m_ADR_O      out  32  BASE | {29'b0, offset}
//  m_DAT_O      out  32  {24'b0, wdata}
//  m_DAT_I      in   32  read data, byte in [7:0]
//  m_WE_O       out  1   write enable
//  m_SEL_O      out  4   constant 4'b0001
//  m_STB_O      out  1   strobe
//  m_CYC_O      out  1   cycle
//  m_ACK_I      in   1   UART acknowledge
//  sN_REQ_I     in   1   requester N (N=0,1) request; held until sN_ACK_O or sN_ERR_O
//  sN_WE_I      in   1   requester N write
//  sN_ADR_I     in   3   requester N register offset
//  sN_DAT_I     in   8   requester N write data
//  sN_DAT_O     out  8   requester N read data, valid while sN_ACK_O=1
//  sN_ACK_O     out  1   one-cycle completion pulse
//  sN_ERR_O     out  1   one-cycle timeout pulse (instead of ACK)
//  reinit_i     in   1   pulse: rerun init sequence
//  init_done_o  out  1   1 once init sequence finished
//  init_err_o   out  1   sticky: an init step timed out
// BEHAVIOUR
//  Reset (RST_I high at an edge): m_STB_O/m_CYC_O/m_WE_O=0, m_ADR_O=BASE, m_DAT_O=0, sN_ACK_O/sN_ERR_O=0,
//   sN_DAT_O=0, init_done_o=0, init_err_o=0, rr pointer=s0 preferred, FSM=INIT_ISSUE step 0.
//   Reset mid-cycle drops STB/CYC at that edge; no ACK/ERR issued for the aborted cycle.
//  FSM: INIT_ISSUE -> INIT_WAIT -> (next step | IDLE); IDLE -> BUS_WAIT -> RESP -> IDLE.
//  Init steps (all writes, in order): off3=0x80; off0=DIVISOR[7:0]; off1=DIVISOR[15:8]; off3=LCR_FMT;
//   off2=FCR_VAL; off1=IER_VAL. Six Wishbone cycles; init_done_o=1 on the edge after step 5 ends.
//  Wishbone cycle: STB=CYC=1 registered, held with stable ADR/DAT/WE until m_ACK_I sampled 1;
//   STB/CYC drop on the same edge that samples ACK. Zero-wait slave: 2 cycles/transfer (STB, then idle).
//  Back-to-back: at least one idle cycle (STB=0) between transfers.
//  Timeout: counter cleared at STB rise; if TIMEOUT edges pass with ACK=0, drop STB/CYC.
//   Init step: set init_err_o, continue with next step. Requester cycle: pulse sN_ERR_O, sN_DAT_O=8'hFF.
//  Arbitration (IDLE, init_done_o=1): one req -> grant it; both -> grant the one not last granted.
//   Grant latched; STB rises on the edge after grant. Requests during init wait (no ACK) until IDLE.
//  Completion: ACK sampled -> RESP: sN_ACK_O=1 for one cycle, sN_DAT_O=m_DAT_I[7:0] captured at ACK
//   (reads; writes return 0). Requester must drop or change REQ after ACK; a REQ still high in IDLE
//   is treated as a new request.
//  reinit_i: in IDLE -> init_done_o=0, restart at step 0 next edge (init_err_o cleared).
//   During an active cycle it is latched and taken when FSM returns to IDLE; duplicates collapse.
//   reinit_i and a request in the same IDLE cycle: reinit wins; request waits.
//  Only one outstanding cycle ever; m_SEL_O constant 4'b0001.
// TESTING
//  T1 reset, ACK returned 1 cycle after STB -> six writes: ADR 0x1250_0003/0000/0001/0003/0002/0001,
//     DAT 0x80,0x01,0x00,0x03,0x07,0x01; init_done_o=1, init_err_o=0.
//  T2 after init, s0 read off5, slave returns 0x60 -> s0_ACK_O one pulse, s0_DAT_O=0x60, s1 untouched.
//  T3 s0,s1 request same cycle, repeated 4x -> grants alternate s0,s1,s0,s1; never two cycles of STB overlap.
//  T4 slave never ACKs s1 write -> STB held exactly TIMEOUT(16) cycles, then s1_ERR_O pulse, no s1_ACK_O.
//  T5 reinit_i during s0 cycle -> s0 completes first, then six init writes, init_done_o low meanwhile.
//  T6 RST_I asserted while STB=1 during init step 2 -> STB=0 next edge, init restarts at step 0 (off3=0x80).

Source files
------------

// File: rtl/uart_8250_bus_ctrl.sv
// Wishbone master for the uart_8250 register port: runs the post-reset init
// sequence, then shares the port round-robin between two requesters.
module uart_8250_bus_ctrl #(
  parameter logic [31:0] BASE    = 32'h1250_0000,
  parameter logic [15:0] DIVISOR = 16'd1,
  parameter logic [7:0]  LCR_FMT = 8'h03,
  parameter logic [7:0]  FCR_VAL = 8'h07,
  parameter logic [7:0]  IER_VAL = 8'h01,
  parameter int          TIMEOUT = 16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  output logic [31:0] m_ADR_O,
  output logic [31:0] m_DAT_O,
  input  logic [31:0] m_DAT_I,
  output logic        m_WE_O,
  output logic [3:0]  m_SEL_O,
  output logic        m_STB_O,
  output logic        m_CYC_O,
  input  logic        m_ACK_I,
  input  logic        s0_REQ_I,
  input  logic        s0_WE_I,
  input  logic [2:0]  s0_ADR_I,
  input  logic [7:0]  s0_DAT_I,
  output logic [7:0]  s0_DAT_O,
  output logic        s0_ACK_O,
  output logic        s0_ERR_O,
  input  logic        s1_REQ_I,
  input  logic        s1_WE_I,
  input  logic [2:0]  s1_ADR_I,
  input  logic [7:0]  s1_DAT_I,
  output logic [7:0]  s1_DAT_O,
  output logic        s1_ACK_O,
  output logic        s1_ERR_O,
  input  logic        reinit_i,
  output logic        init_done_o,
  output logic        init_err_o
);

  // state      | meaning
  // INIT_ISSUE | raise STB for the current init step
  // INIT_WAIT  | init write in flight, wait for ACK or timeout
  // IDLE       | arbitrate requesters, or take a pending reinit
  // BUS_WAIT   | requester cycle: raise STB, then wait for ACK or timeout
  // RESP       | one-cycle ACK/ERR pulse to the granted requester
  localparam logic [2:0] INIT_ISSUE = 3'd0;
  localparam logic [2:0] INIT_WAIT  = 3'd1;
  localparam logic [2:0] IDLE       = 3'd2;
  localparam logic [2:0] BUS_WAIT   = 3'd3;
  localparam logic [2:0] RESP       = 3'd4;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [2:0]    step;
  logic [2:0]    off;
  logic [7:0]    wdata;
  logic [TW-1:0] tmr;
  logic          gnt;
  logic          prefer;
  logic          reinit_pend;

  logic [2:0]    init_off;
  logic [7:0]    init_dat;
  logic          nxt_gnt;
  logic          req_we;
  logic [2:0]    req_adr;
  logic [7:0]    req_dat;
  logic          tmr_done;
  logic          unused_dat_hi;

  assign unused_dat_hi = ^m_DAT_I[31:8];

  assign m_ADR_O = BASE | {29'b0, off};
  assign m_DAT_O = {24'b0, wdata};
  assign m_SEL_O = 4'b0001;
  assign tmr_done = (tmr == '0);

  always_comb begin
    init_off = 3'd1;
    init_dat = IER_VAL;
    case (step)
      3'd0: begin init_off = 3'd3; init_dat = 8'h80;          end
      3'd1: begin init_off = 3'd0; init_dat = DIVISOR[7:0];   end
      3'd2: begin init_off = 3'd1; init_dat = DIVISOR[15:8];  end
      3'd3: begin init_off = 3'd3; init_dat = LCR_FMT;        end
      3'd4: begin init_off = 3'd2; init_dat = FCR_VAL;        end
      default: begin init_off = 3'd1; init_dat = IER_VAL;     end
    endcase
  end

  // prefer=0 favours s0 when both request
  always_comb begin
    nxt_gnt = (s0_REQ_I && s1_REQ_I) ? prefer : s1_REQ_I;
    req_we  = gnt ? s1_WE_I  : s0_WE_I;
    req_adr = gnt ? s1_ADR_I : s0_ADR_I;
    req_dat = gnt ? s1_DAT_I : s0_DAT_I;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state       <= INIT_ISSUE;
      step        <= 3'd0;
      off         <= 3'd0;
      wdata       <= 8'h00;
      tmr         <= '0;
      gnt         <= 1'b0;
      prefer      <= 1'b0;
      reinit_pend <= 1'b0;
      m_STB_O     <= 1'b0;
      m_CYC_O     <= 1'b0;
      m_WE_O      <= 1'b0;
      s0_ACK_O    <= 1'b0;
      s0_ERR_O    <= 1'b0;
      s0_DAT_O    <= 8'h00;
      s1_ACK_O    <= 1'b0;
      s1_ERR_O    <= 1'b0;
      s1_DAT_O    <= 8'h00;
      init_done_o <= 1'b0;
      init_err_o  <= 1'b0;
    end else begin
      s0_ACK_O <= 1'b0;
      s0_ERR_O <= 1'b0;
      s1_ACK_O <= 1'b0;
      s1_ERR_O <= 1'b0;
      if (reinit_i) reinit_pend <= 1'b1;
      if (m_STB_O && !tmr_done) tmr <= tmr - TW'(1);

      case (state)
        INIT_ISSUE: begin
          m_STB_O <= 1'b1;
          m_CYC_O <= 1'b1;
          m_WE_O  <= 1'b1;
          off     <= init_off;
          wdata   <= init_dat;
          tmr     <= TMR_LOAD;
          state   <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (m_ACK_I || tmr_done) begin
            m_STB_O <= 1'b0;
            m_CYC_O <= 1'b0;
            m_WE_O  <= 1'b0;
            if (!m_ACK_I) init_err_o <= 1'b1;
            if (step == 3'd5) begin
              init_done_o <= 1'b1;
              state       <= IDLE;
            end else begin
              step  <= step + 3'd1;
              state <= INIT_ISSUE;
            end
          end
        end
        IDLE: begin
          if (reinit_i || reinit_pend) begin
            reinit_pend <= 1'b0;
            init_done_o <= 1'b0;
            init_err_o  <= 1'b0;
            step        <= 3'd0;
            state       <= INIT_ISSUE;
          end else if (s0_REQ_I || s1_REQ_I) begin
            gnt    <= nxt_gnt;
            prefer <= ~nxt_gnt;
            state  <= BUS_WAIT;
          end
        end
        BUS_WAIT: begin
          if (!m_STB_O) begin
            m_STB_O <= 1'b1;
            m_CYC_O <= 1'b1;
            m_WE_O  <= req_we;
            off     <= req_adr;
            wdata   <= req_dat;
            tmr     <= TMR_LOAD;
          end else if (m_ACK_I || tmr_done) begin
            m_STB_O <= 1'b0;
            m_CYC_O <= 1'b0;
            m_WE_O  <= 1'b0;
            state   <= RESP;
            if (m_ACK_I) begin
              if (gnt) begin
                s1_ACK_O <= 1'b1;
                s1_DAT_O <= m_WE_O ? 8'h00 : m_DAT_I[7:0];
              end else begin
                s0_ACK_O <= 1'b1;
                s0_DAT_O <= m_WE_O ? 8'h00 : m_DAT_I[7:0];
              end
            end else if (gnt) begin
              s1_ERR_O <= 1'b1;
              s1_DAT_O <= 8'hFF;
            end else begin
              s0_ERR_O <= 1'b1;
              s0_DAT_O <= 8'hFF;
            end
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_8250_bus_ctrl.sv
// Directed bench for uart_8250_bus_ctrl: init sequence, reads, round-robin,
// timeout, reinit and mid-cycle reset, with a zero-wait slave model.
module tb_uart_8250_bus_ctrl;

  localparam logic [31:0] BASE = 32'h1250_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_adr, m_dat_o, m_dat_i;
  logic        m_we, m_stb, m_cyc, m_ack;
  logic [3:0]  m_sel;
  logic        s0_req, s0_we, s1_req, s1_we;
  logic [2:0]  s0_adr, s1_adr;
  logic [7:0]  s0_wd, s1_wd, s0_rd, s1_rd;
  logic        s0_ack, s0_err, s1_ack, s1_err;
  logic        reinit, init_done, init_err;

  logic        ack_en;
  logic [7:0]  rd_data;

  typedef struct {
    logic [31:0] adr;
    logic [7:0]  dat;
    logic        we;
    logic        done;
  } xfer_t;
  xfer_t log_q[$];

  int tests = 0;
  int fails = 0;
  int s0_ack_cnt = 0, s1_ack_cnt = 0, s1_err_cnt = 0;
  int stb_run = 0, stb_len = 0, gap_viol = 0;
  logic prev_fin = 1'b0;

  assign m_ack   = ack_en && m_stb;
  assign m_dat_i = {24'hABCDEF, rd_data};

  always #5 clk = ~clk;

  uart_8250_bus_ctrl dut (
    .CLK_I(clk), .RST_I(rst),
    .m_ADR_O(m_adr), .m_DAT_O(m_dat_o), .m_DAT_I(m_dat_i), .m_WE_O(m_we),
    .m_SEL_O(m_sel), .m_STB_O(m_stb), .m_CYC_O(m_cyc), .m_ACK_I(m_ack),
    .s0_REQ_I(s0_req), .s0_WE_I(s0_we), .s0_ADR_I(s0_adr), .s0_DAT_I(s0_wd),
    .s0_DAT_O(s0_rd), .s0_ACK_O(s0_ack), .s0_ERR_O(s0_err),
    .s1_REQ_I(s1_req), .s1_WE_I(s1_we), .s1_ADR_I(s1_adr), .s1_DAT_I(s1_wd),
    .s1_DAT_O(s1_rd), .s1_ACK_O(s1_ack), .s1_ERR_O(s1_err),
    .reinit_i(reinit), .init_done_o(init_done), .init_err_o(init_err)
  );

  // Bus monitor: completed transfers, pulse counts, STB run length, idle gap
  always @(negedge clk) begin
    if (m_stb && m_ack) log_q.push_back('{m_adr, m_dat_o[7:0], m_we, init_done});
    if (m_stb && prev_fin) gap_viol++;
    prev_fin = m_stb && m_ack;
    if (m_stb) stb_run++;
    else if (stb_run != 0) begin
      stb_len = stb_run;
      stb_run = 0;
    end
    if (s0_ack) s0_ack_cnt++;
    if (s1_ack) s1_ack_cnt++;
    if (s1_err) s1_err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_init_done();
    for (int i = 0; i < 300 && !init_done; i++) tick(1);
    chk("init_done", {31'b0, init_done}, 32'd1);
  endtask

  task automatic chk_init_log(input int base_idx, input string tag);
    logic [31:0] ea[6];
    logic [7:0]  ed[6];
    ea = '{BASE | 3, BASE | 0, BASE | 1, BASE | 3, BASE | 2, BASE | 1};
    ed = '{8'h80, 8'h01, 8'h00, 8'h03, 8'h07, 8'h01};
    for (int k = 0; k < 6; k++) begin
      if (log_q.size() > base_idx + k) begin
        chk({tag, "_adr"}, log_q[base_idx + k].adr, ea[k]);
        chk({tag, "_dat"}, {24'b0, log_q[base_idx + k].dat}, {24'b0, ed[k]});
        chk({tag, "_we"}, {31'b0, log_q[base_idx + k].we}, 32'd1);
      end
    end
  endtask

  initial begin
    logic got;
    int n0, n1;
    rst = 1'b1; ack_en = 1'b0; rd_data = 8'h00; reinit = 1'b0;
    s0_req = 0; s0_we = 0; s0_adr = 0; s0_wd = 0;
    s1_req = 0; s1_we = 0; s1_adr = 0; s1_wd = 0;
    tick(3);

    // reset state
    chk("rst_stb", {31'b0, m_stb}, 32'd0);
    chk("rst_cyc", {31'b0, m_cyc}, 32'd0);
    chk("rst_we", {31'b0, m_we}, 32'd0);
    chk("rst_adr", m_adr, BASE);
    chk("rst_dat", m_dat_o, 32'd0);
    chk("rst_sel", {28'b0, m_sel}, 32'd1);
    chk("rst_done", {31'b0, init_done}, 32'd0);
    chk("rst_err", {31'b0, init_err}, 32'd0);
    chk("rst_s0dat", {24'b0, s0_rd}, 32'd0);

    // T1: init sequence
    log_q.delete();
    ack_en = 1'b1;
    rst = 1'b0;
    wait_init_done();
    chk("t1_cnt", log_q.size(), 32'd6);
    chk_init_log(0, "t1");
    chk("t1_err", {31'b0, init_err}, 32'd0);

    // T2: s0 reads offset 5
    log_q.delete(); s0_ack_cnt = 0; s1_ack_cnt = 0; s1_err_cnt = 0;
    rd_data = 8'h60;
    s0_req = 1; s0_we = 0; s0_adr = 3'd5;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick(1);
      if (s0_ack) begin
        got = 1;
        chk("t2_rdata", {24'b0, s0_rd}, 32'h60);
      end
    end
    s0_req = 0;
    chk("t2_ack_seen", {31'b0, got}, 32'd1);
    tick(4);
    chk("t2_ack_pulses", s0_ack_cnt, 32'd1);
    chk("t2_s1_ack", s1_ack_cnt + s1_err_cnt, 32'd0);
    chk("t2_cnt", log_q.size(), 32'd1);
    if (log_q.size() == 1) begin
      chk("t2_adr", log_q[0].adr, BASE | 5);
      chk("t2_we", {31'b0, log_q[0].we}, 32'd0);
    end

    // T4: slave never acks an s1 write (runs before T3 so s1 is last granted)
    ack_en = 1'b0; s1_err_cnt = 0; s1_ack_cnt = 0;
    s1_req = 1; s1_we = 1; s1_adr = 3'd0; s1_wd = 8'h55;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick(1);
      if (s1_err) begin
        got = 1;
        chk("t4_errdat", {24'b0, s1_rd}, 32'hFF);
      end
    end
    s1_req = 0;
    chk("t4_err_seen", {31'b0, got}, 32'd1);
    tick(3);
    chk("t4_stb_len", stb_len, 32'd16);
    chk("t4_err_pulses", s1_err_cnt, 32'd1);
    chk("t4_no_ack", s1_ack_cnt, 32'd0);
    ack_en = 1'b1;

    // T3: both request together, 4 rounds -> s0,s1,s0,s1,...
    log_q.delete(); gap_viol = 0;
    s0_we = 1; s0_adr = 3'd7; s1_we = 1; s1_adr = 3'd7;
    for (int r = 0; r < 4; r++) begin
      s0_wd = 8'hA0 + 8'(r); s1_wd = 8'hB0 + 8'(r);
      s0_req = 1; s1_req = 1;
      for (int i = 0; i < 60 && (s0_req || s1_req); i++) begin
        tick(1);
        if (s0_ack) s0_req = 0;
        if (s1_ack) s1_req = 0;
      end
      chk("t3_round_done", {30'b0, s0_req, s1_req}, 32'd0);
      s0_req = 0; s1_req = 0;
    end
    tick(3);
    chk("t3_cnt", log_q.size(), 32'd8);
    n0 = 0; n1 = 0;
    for (int k = 0; k < 8 && k < log_q.size(); k++) begin
      if (k % 2 == 0) chk("t3_order_s0", {24'b0, log_q[k].dat}, {24'b0, 8'hA0 + 8'(n0++)});
      else            chk("t3_order_s1", {24'b0, log_q[k].dat}, {24'b0, 8'hB0 + 8'(n1++)});
    end
    chk("t3_gap", gap_viol, 32'd0);

    // T5: reinit during an s0 cycle
    log_q.delete();
    s0_req = 1; s0_we = 1; s0_adr = 3'd4; s0_wd = 8'h0B;
    tick(1);
    reinit = 1;
    tick(1);
    reinit = 0;
    chk("t5_stb_active", {31'b0, m_stb}, 32'd1);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick(1);
      if (s0_ack) got = 1;
    end
    s0_req = 0;
    chk("t5_s0_ack", {31'b0, got}, 32'd1);
    tick(2);
    chk("t5_done_low", {31'b0, init_done}, 32'd0);
    wait_init_done();
    chk("t5_cnt", log_q.size(), 32'd7);
    if (log_q.size() >= 1) begin
      chk("t5_first_adr", log_q[0].adr, BASE | 4);
      chk("t5_first_dat", {24'b0, log_q[0].dat}, 32'h0B);
    end
    chk_init_log(1, "t5");
    for (int k = 1; k < 7 && k < log_q.size(); k++)
      chk("t5_done_during", {31'b0, log_q[k].done}, 32'd0);

    // T6: reset while STB is high for init step 2
    log_q.delete();
    reinit = 1;
    tick(1);
    reinit = 0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick(1);
      if (log_q.size() == 2 && m_stb) got = 1;
    end
    chk("t6_at_step2", {31'b0, got}, 32'd1);
    chk("t6_step2_adr", m_adr, BASE | 1);
    rst = 1;
    tick(1);
    chk("t6_stb_drop", {31'b0, m_stb}, 32'd0);
    chk("t6_cyc_drop", {31'b0, m_cyc}, 32'd0);
    chk("t6_done_low", {31'b0, init_done}, 32'd0);
    log_q.delete();
    rst = 0;
    wait_init_done();
    chk("t6_cnt", log_q.size(), 32'd6);
    chk_init_log(0, "t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
